// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the RV32 fetch-stage program-counter generator.
//   pc_state_e    : control state of pc_gen (BOOT, RUN, HALT)
//   ialign_legal  : true for the supported instruction alignments (2 or 4)
//   IALIGN_LEGAL_MASK : bit i set when an alignment of i bytes is supported
// -----------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    // Supported alignments are 2 (compressed ISA) and 4 bytes.
    localparam logic [7:0] IALIGN_LEGAL_MASK = 8'b0001_0100;

    function automatic bit ialign_legal(input int unsigned ialign);
        return (ialign < 8) && IALIGN_LEGAL_MASK[ialign[2:0]];
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
// Combinational next-PC priority mux for pc_gen.
//   Inputs : state_i, pc_i (current PC), stall_i, if_ready_i,
//            redirect_valid_i / redirect_target_i, trap_req_i / trap_pc_i,
//            halt_req_i
//   Outputs: pc_next_o    next PC value
//            epc_load_o   capture epc_next_o into the exception PC register
//            epc_next_o   value to capture (trap PC or misaligned target)
//            misaligned_o redirect target is not IALIGN-aligned
//            halt_take_o  a halt request wins this cycle (RUN only)
// Priority (highest first): trap, redirect, halt, hold (stall / !if_ready),
// sequential increment. Trap and redirect act in RUN and HALT; nothing
// acts in BOOT.
// -----------------------------------------------------------------------------
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int unsigned     IALIGN      = 4
) (
    input  pc_state_e         state_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              stall_i,
    input  logic              if_ready_i,
    input  logic              redirect_valid_i,
    input  logic [XLEN-1:0]   redirect_target_i,
    input  logic              trap_req_i,
    input  logic [XLEN-1:0]   trap_pc_i,
    input  logic              halt_req_i,
    output logic [XLEN-1:0]   pc_next_o,
    output logic              epc_load_o,
    output logic [XLEN-1:0]   epc_next_o,
    output logic              misaligned_o,
    output logic              halt_take_o
);

    // An unsupported IALIGN falls back to 4-byte alignment.
    localparam int unsigned     IALIGN_EFF = ialign_legal(IALIGN) ? IALIGN : 4;
    localparam logic [XLEN-1:0] INCR       = XLEN'(IALIGN_EFF);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN_EFF - 1);

    logic target_misaligned;
    assign target_misaligned = (redirect_target_i & ALIGN_MASK) != '0;

    always_comb begin
        pc_next_o    = pc_i;
        epc_load_o   = 1'b0;
        epc_next_o   = trap_pc_i;
        misaligned_o = 1'b0;
        halt_take_o  = 1'b0;
        if (state_i != ST_BOOT) begin
            if (trap_req_i) begin
                pc_next_o  = TRAP_VECTOR;
                epc_load_o = 1'b1;
                epc_next_o = trap_pc_i;
            end else if (redirect_valid_i) begin
                if (target_misaligned) begin
                    // Misaligned jump is turned into a trap on the target.
                    pc_next_o    = TRAP_VECTOR;
                    epc_load_o   = 1'b1;
                    epc_next_o   = redirect_target_i;
                    misaligned_o = 1'b1;
                end else begin
                    pc_next_o = redirect_target_i;
                end
            end else if (state_i == ST_RUN) begin
                if (halt_req_i) begin
                    halt_take_o = 1'b1;
                end else if (!stall_i && if_ready_i) begin
                    // Advance only when the fetch port accepted this PC.
                    pc_next_o = pc_i + INCR;
                end
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// Program-counter generator for the RV32 fetch stage.
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   stall               : hazard stall, hold PC
//   redirect_valid/_target : taken branch/jump
//   trap_req / trap_pc  : exception or interrupt, PC of faulting instruction
//   halt_req / resume   : enter / leave HALT
//   if_ready            : fetch port accepts current PC
//   if_valid            : current PC is a valid fetch request (RUN only)
//   pc_output / pc_plus : current PC and PC + IALIGN (link value)
//   epc                 : captured exception PC
//   misaligned          : one-cycle pulse on a misaligned redirect
//   halted              : state is HALT
//   dbg_state           : current control state, for observation
// Handshake: a PC is consumed on a rising edge where if_valid and if_ready are
// both high; while if_valid is high and if_ready low, pc_output only moves on
// a trap or redirect.
// -----------------------------------------------------------------------------
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned     IALIGN       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_target,
    input  logic              trap_req,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              if_ready,
    output logic              if_valid,
    output logic [XLEN-1:0]   pc_output,
    output logic [XLEN-1:0]   pc_plus,
    output logic [XLEN-1:0]   epc,
    output logic              misaligned,
    output logic              halted,
    output pc_state_e         dbg_state
);

    localparam int unsigned     IALIGN_EFF = ialign_legal(IALIGN) ? IALIGN : 4;
    localparam logic [XLEN-1:0] INCR       = XLEN'(IALIGN_EFF);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            mis_q, mis_d;

    logic            epc_load;
    logic [XLEN-1:0] epc_next;
    logic            halt_take;

    pc_next_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .IALIGN      (IALIGN)
    ) u_next_sel (
        .state_i           (state_q),
        .pc_i              (pc_q),
        .stall_i           (stall),
        .if_ready_i        (if_ready),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .trap_req_i        (trap_req),
        .trap_pc_i         (trap_pc),
        .halt_req_i        (halt_req),
        .pc_next_o         (pc_d),
        .epc_load_o        (epc_load),
        .epc_next_o        (epc_next),
        .misaligned_o      (mis_d),
        .halt_take_o       (halt_take)
    );

    assign epc_d = epc_load ? epc_next : epc_q;

    // Control FSM: BOOT is a single dead cycle after reset release.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (halt_take) state_d = ST_HALT;
            ST_HALT: if (resume) state_d = ST_RUN;  // resume beats halt_req
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            epc_q <= '0;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            mis_q <= mis_d;
        end
    end

    assign if_valid   = (state_q == ST_RUN);
    assign halted     = (state_q == ST_HALT);
    assign pc_output  = pc_q;
    assign pc_plus    = pc_q + INCR;
    assign epc        = epc_q;
    assign misaligned = mis_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
    import pc_pkg::*;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
    localparam longint      IALIGN    = 4;
    localparam longint      PC_MOD    = 64'h1_0000_0000;
    localparam int          W         = 67;

    localparam int MODE_BOOT = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_HALT = 2;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        stall, redirect_valid, trap_req, halt_req, resume, if_ready;
    logic [31:0] redirect_target, trap_pc;
    logic        if_valid, misaligned, halted;
    logic [31:0] pc_output, pc_plus, epc;
    pc_state_e   dbg_state;

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (RESET_VEC),
        .TRAP_VECTOR  (TRAP_VEC),
        .IALIGN       (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_req        (trap_req),
        .trap_pc         (trap_pc),
        .halt_req        (halt_req),
        .resume          (resume),
        .if_ready        (if_ready),
        .if_valid        (if_valid),
        .pc_output       (pc_output),
        .pc_plus         (pc_plus),
        .epc             (epc),
        .misaligned      (misaligned),
        .halted          (halted),
        .dbg_state       (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int check_cnt = 0;
    int pass_cnt  = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endfunction

    // ---------------- reference model ----------------
    int          m_mode;
    longint      m_pc, m_epc;
    bit          m_mis;

    function automatic void model_reset();
        m_mode = MODE_BOOT;
        m_pc   = longint'(RESET_VEC);
        m_epc  = 0;
        m_mis  = 1'b0;
    endfunction

    function automatic void model_step(input bit st, input bit rv, input logic [31:0] tgt,
                                       input bit tr, input logic [31:0] tpc,
                                       input bit hr, input bit rs, input bit rdy);
        int prev;
        bit mis_n;
        prev  = m_mode;
        mis_n = 1'b0;
        if (prev == MODE_BOOT) begin
            m_mode = MODE_RUN;
        end else begin
            if (tr) begin
                m_pc  = longint'(TRAP_VEC);
                m_epc = longint'(tpc);
            end else if (rv) begin
                if (longint'(tgt) % IALIGN != 0) begin
                    m_pc  = longint'(TRAP_VEC);
                    m_epc = longint'(tgt);
                    mis_n = 1'b1;
                end else begin
                    m_pc = longint'(tgt);
                end
            end else if (prev == MODE_RUN) begin
                if (hr) m_mode = MODE_HALT;
                else if (!st && rdy) m_pc = (m_pc + IALIGN) % PC_MOD;
            end
            if (prev == MODE_HALT && rs) m_mode = MODE_RUN;
        end
        m_mis = mis_n;
    endfunction

    function automatic void push_expected();
        logic [31:0] p, e;
        p = m_pc[31:0];
        e = m_epc[31:0];
        exp_q.push_back({m_mode == MODE_RUN, m_mode == MODE_HALT, m_mis, p, e});
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        if (!reset && exp_q.size() != 0) begin
            logic [W-1:0] e;
            logic [31:0]  e_pc;
            e    = exp_q.pop_front();
            e_pc = e[63:32];
            check("if_valid",   {31'd0, if_valid},   {31'd0, e[66]});
            check("halted",     {31'd0, halted},     {31'd0, e[65]});
            check("dbg_halt",   {31'd0, dbg_state == ST_HALT}, {31'd0, e[65]});
            check("misaligned", {31'd0, misaligned}, {31'd0, e[64]});
            check("pc_output",  pc_output,           e_pc);
            check("pc_plus",    pc_plus,             e_pc + 32'd4);
            check("epc",        epc,                 e[31:0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_cycle(input bit st, input bit rv, input logic [31:0] tgt,
                               input bit tr, input logic [31:0] tpc,
                               input bit hr, input bit rs, input bit rdy);
        @(negedge clk);
        stall = st; redirect_valid = rv; redirect_target = tgt;
        trap_req = tr; trap_pc = tpc; halt_req = hr; resume = rs; if_ready = rdy;
        model_step(st, rv, tgt, tr, tpc, hr, rs, rdy);
        push_expected();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 32'd0, 0, 32'd0, 0, 0, 1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        stall = 0; redirect_valid = 0; redirect_target = 0; trap_req = 0;
        trap_pc = 0; halt_req = 0; resume = 0; if_ready = 1;
        model_reset();
        model_step(0, 0, 32'd0, 0, 32'd0, 0, 0, 1);
        push_expected();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},       pc_output,           RESET_VEC);
        check({tag, "_if_valid"}, {31'd0, if_valid},   32'd0);
        check({tag, "_halted"},   {31'd0, halted},     32'd0);
        check({tag, "_epc"},      epc,                 32'd0);
        check({tag, "_mis"},      {31'd0, misaligned}, 32'd0);
    endtask

    // Asserts reset between clock edges and checks the outputs react at once.
    task automatic async_reset_pulse();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        repeat (2) @(posedge clk);
        release_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        stall = 0; redirect_valid = 0; redirect_target = 0; trap_req = 0;
        trap_pc = 0; halt_req = 0; resume = 0; if_ready = 1;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_values("reset");
        @(posedge clk);
        release_reset();

        // Sequential fetch: 0, 4, 8, C, 10
        idle(4);
        // Stall holds at 0x10, then advances
        repeat (3) drive_cycle(1, 0, 32'd0, 0, 32'd0, 0, 0, 1);
        idle(1);
        // Fetch port not ready holds at 0x14
        repeat (3) drive_cycle(0, 0, 32'd0, 0, 32'd0, 0, 0, 0);
        idle(1);
        // Redirect wins over stall
        drive_cycle(1, 1, 32'h200, 0, 32'd0, 0, 0, 1);
        idle(1);
        check("redir_under_stall", pc_output, 32'h200);
        // Misaligned redirect
        drive_cycle(0, 1, 32'h202, 0, 32'd0, 0, 0, 1);
        idle(1);
        check("mis_pc",  pc_output, TRAP_VEC);
        check("mis_epc", epc, 32'h202);
        check("mis_set", {31'd0, misaligned}, 32'd1);
        idle(1);
        check("mis_clear", {31'd0, misaligned}, 32'd0);
        // Trap beats redirect in the same cycle
        drive_cycle(0, 1, 32'h300, 1, 32'h40, 0, 0, 1);
        idle(1);
        check("trap_pc",  pc_output, TRAP_VEC);
        check("trap_epc", epc, 32'h40);
        // Halt at 0x20, hold, trap while halted, resume together with halt_req
        drive_cycle(0, 1, 32'h20, 0, 32'd0, 0, 0, 1);
        drive_cycle(0, 0, 32'd0, 0, 32'd0, 1, 0, 1);
        idle(5);
        check("halt_hold_pc", pc_output, 32'h20);
        check("halt_flag",    {31'd0, halted}, 32'd1);
        check("halt_ifvalid", {31'd0, if_valid}, 32'd0);
        drive_cycle(0, 0, 32'd0, 0, 32'd0, 1, 1, 1);
        idle(2);
        drive_cycle(0, 0, 32'd0, 0, 32'd0, 1, 0, 1);
        drive_cycle(0, 0, 32'd0, 1, 32'h88, 0, 0, 1);
        drive_cycle(0, 0, 32'd0, 0, 32'd0, 0, 1, 1);
        idle(2);
        // Wrap at top of address space
        drive_cycle(0, 1, 32'hFFFF_FFFC, 0, 32'd0, 0, 0, 1);
        idle(2);
        // Mid-stream asynchronous reset
        async_reset_pulse();
        idle(2);

        // Randomised traffic with one more reset in the middle
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFFC;
            drive_cycle($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, tgt,
                        $urandom_range(0, 19) == 0, $urandom,
                        $urandom_range(0, 14) == 0, $urandom_range(0, 4) == 0,
                        $urandom_range(0, 4) != 0);
            if (i == 200) async_reset_pulse();
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
